mdu_ctrl: RTL and testbench

MDU_CTRL -- requirements
Module: mdu_ctrl

---
 rtl/mdu_pkg.sv | 31 +++
 rtl/mdu_step.sv | 35 +++
 rtl/mdu_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_mdu_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared encodings and sizing for the multiply/divide unit.
// Holds the op encoding, FSM state encoding, iteration count and counter width.
package mdu_pkg;

    localparam int MDU_ITER = 32;
    localparam int CNT_W    = 6;

    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_MULT  = 2'b01,
        OP_DIVU  = 2'b10,
        OP_DIV   = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIX  = 2'b10
    } mdu_state_e;

    // Divide ops are the ones with the upper op bit set.
    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    // The lower op bit picks the signed variant when signed support is built in.
    function automatic logic op_is_signed(input logic [1:0] op);
        return op[0];
    endfunction

endpackage

// File: rtl/mdu_step.sv
// mdu_step: one radix-2 iteration of the multiply/divide datapath.
// The 64-bit accumulator is shared by both operations:
//   multiply: {partial product, remaining multiplier bits}, shifted right each step
//   divide:   {partial remainder, remaining dividend / growing quotient}, shifted left
module mdu_step
    import mdu_pkg::*;
(
    input  logic        is_div,
    input  logic [63:0] acc,
    input  logic [31:0] operand,
    output logic [63:0] acc_next
);

    logic [32:0] mul_sum;
    logic [32:0] rem_shift;
    logic [33:0] diff;

    // Shift-add for multiply, restoring shift-subtract for divide.
    always_comb begin
        mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, operand} : 33'd0);
        rem_shift = {acc[63:32], acc[31]};
        diff      = {1'b0, rem_shift} - {2'b00, operand};
        acc_next  = acc;
        if (is_div) begin
            if (!diff[33]) begin
                acc_next = {diff[31:0], acc[30:0], 1'b1};
            end else begin
                acc_next = {rem_shift[31:0], acc[30:0], 1'b0};
            end
        end else begin
            acc_next = {mul_sum, acc[31:1]};
        end
    end

endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: iterative MIPS-style multiply/divide unit with HI/LO registers.
// Fixed 33-cycle latency: 32 RUN steps then one FIX cycle that writes HI/LO.
// Optional macro MDU_SIGNED_EN enables MULT/DIV signed handling (op[0]=1);
// without it every op is unsigned and FIX is a plain pass-through.
module mdu_ctrl
    import mdu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cancel,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        dz,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    mdu_state_e       state;
    mdu_state_e       state_next;
    logic [CNT_W-1:0] cnt;
    logic [63:0]      acc;
    logic [63:0]      acc_next;
    logic [31:0]      operand;
    logic             is_div;
    logic             dz_pend;
    logic             accept;
    logic             dz_hit;
    logic             fix_commit;
    logic [31:0]      a_mag;
    logic [31:0]      b_mag;
    logic [63:0]      result;

`ifdef MDU_SIGNED_EN
    logic             a_neg;
    logic             b_neg;
    logic             res_neg;
    logic             rem_neg;

    // Signed ops iterate on magnitudes; remember which signs to restore in FIX.
    always_comb begin
        a_neg = op_is_signed(op) & a[31];
        b_neg = op_is_signed(op) & b[31];
        a_mag = a_neg ? (~a + 32'd1) : a;
        b_mag = b_neg ? (~b + 32'd1) : b;
    end

    // Sign flags are captured together with the operands.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_neg <= 1'b0;
            rem_neg <= 1'b0;
        end else if (accept) begin
            res_neg <= a_neg ^ b_neg;
            rem_neg <= a_neg;
        end
    end

    // Product/quotient negate on differing signs; remainder follows the dividend.
    always_comb begin
        result = acc;
        if (is_div) begin
            result[31:0]  = res_neg ? (~acc[31:0] + 32'd1) : acc[31:0];
            result[63:32] = rem_neg ? (~acc[63:32] + 32'd1) : acc[63:32];
        end else if (res_neg) begin
            result = ~acc + 64'd1;
        end
    end
`else
    logic             unused_op_sign;

    // Unsigned-only build: operands go straight in and FIX passes the result through.
    always_comb begin
        unused_op_sign = op[0];
        a_mag          = a;
        b_mag          = b;
        result         = acc;
    end
`endif

    mdu_step u_step (
        .is_div   (is_div),
        .acc      (acc),
        .operand  (operand),
        .acc_next (acc_next)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode: accept in IDLE, count through RUN, one FIX cycle, cancel aborts.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        dz_hit     = 1'b0;
        fix_commit = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start && !cancel) begin
                    if (op_is_div(op) && (b == 32'd0)) begin
                        dz_hit = 1'b1;
                    end else begin
                        accept     = 1'b1;
                        state_next = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (cancel) begin
                    state_next = ST_IDLE;
                end else if (cnt == CNT_W'(MDU_ITER - 1)) begin
                    state_next = ST_FIX;
                end
            end
            ST_FIX: begin
                state_next = ST_IDLE;
                fix_commit = !cancel;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Operand capture and one datapath iteration per RUN cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            acc     <= '0;
            operand <= '0;
            is_div  <= 1'b0;
        end else if (accept) begin
            cnt     <= '0;
            acc     <= {32'd0, a_mag};
            operand <= b_mag;
            is_div  <= op_is_div(op);
        end else if (state == ST_RUN) begin
            cnt <= cnt + CNT_W'(1);
            acc <= acc_next;
        end
    end

    // HI/LO: result lands in FIX; MTHI/MTLO only take effect while idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi <= '0;
            lo <= '0;
        end else if (fix_commit) begin
            hi <= result[63:32];
            lo <= result[31:0];
        end else if (state == ST_IDLE) begin
            if (hi_we) begin
                hi <= wdata;
            end
            if (lo_we) begin
                lo <= wdata;
            end
        end
    end

    // Completion pulses; a zero divisor reports one cycle after it was issued.
    always_ff @(posedge clk) begin
        if (rst) begin
            dz_pend <= 1'b0;
            done    <= 1'b0;
            dz      <= 1'b0;
        end else begin
            dz_pend <= dz_hit;
            done    <= fix_commit | dz_pend;
            dz      <= dz_pend;
        end
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed checks of latency, results, divide-by-zero, ignore/cancel/reset behaviour.
module tb_mdu_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        cancel;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        dz;
    logic [31:0] hi;
    logic [31:0] lo;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   lat;
    int   busy_cnt;
    int   done_cnt;
    logic dz_seen;

    mdu_ctrl dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .cancel (cancel),
        .hi_we  (hi_we),
        .lo_we  (lo_we),
        .wdata  (wdata),
        .busy   (busy),
        .done   (done),
        .dz     (dz),
        .hi     (hi),
        .lo     (lo)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic writeHiLo(input logic [31:0] h, input logic [31:0] l);
        hi_we = 1'b1;
        wdata = h;
        @(posedge clk); #1;
        hi_we = 1'b0;
        lo_we = 1'b1;
        wdata = l;
        @(posedge clk); #1;
        lo_we = 1'b0;
    endtask

    // Issue one op and watch 40 cycles. evt_kind: 1 second start + MTHI, 2 cancel, 3 reset.
    task automatic applyStimulus(input logic [1:0] op_i, input logic [31:0] a_i, input logic [31:0] b_i,
                                 input int evt_kind, input int evt_cycle);
        op    = op_i;
        a     = a_i;
        b     = b_i;
        start = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        lat      = -1;
        done_cnt = 0;
        dz_seen  = 1'b0;
        busy_cnt = busy ? 1 : 0;
        for (int n = 1; n <= 40; n++) begin
            if (evt_kind == 1 && n == evt_cycle) begin
                start = 1'b1;
                op    = 2'b00;
                a     = 32'd2;
                b     = 32'd3;
            end
            if (evt_kind == 1 && n == evt_cycle + 1) begin
                hi_we = 1'b1;
                wdata = 32'hDEADBEEF;
            end
            if (evt_kind == 2 && n == evt_cycle) cancel = 1'b1;
            if (evt_kind == 3 && n == evt_cycle) rst = 1'b1;
            @(posedge clk); #1;
            start  = 1'b0;
            cancel = 1'b0;
            rst    = 1'b0;
            hi_we  = 1'b0;
            if (done) begin
                done_cnt++;
                if (lat < 0) begin
                    lat     = n;
                    dz_seen = dz;
                end
            end
            if (lat < 0 && busy) busy_cnt++;
        end
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        op     = 2'b00;
        a      = '0;
        b      = '0;
        cancel = 1'b0;
        hi_we  = 1'b0;
        lo_we  = 1'b0;
        wdata  = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("reset_hi", hi, 0);
        checkOutput("reset_lo", lo, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_dz", dz, 0);

        $display("[TB] MULTU max*max");
        applyStimulus(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0);
        checkOutput("multu_lat", 64'(lat), 64'd33);
        checkOutput("multu_busy_cycles", 64'(busy_cnt), 64'd33);
        checkOutput("multu_done_pulses", 64'(done_cnt), 64'd1);
        checkOutput("multu_dz", dz_seen, 0);
        checkOutput("multu_hi", hi, 32'hFFFFFFFE);
        checkOutput("multu_lo", lo, 32'h00000001);

        $display("[TB] DIVU large/16");
        applyStimulus(2'b10, 32'hFFFFFFFF, 32'h10, 0, 0);
        checkOutput("divu_lat", 64'(lat), 64'd33);
        checkOutput("divu_lo", lo, 32'h0FFFFFFF);
        checkOutput("divu_hi", hi, 32'h0000000F);

`ifdef MDU_SIGNED_EN
        $display("[TB] signed MULT / DIV");
        applyStimulus(2'b01, 32'hFFFFFFFD, 32'd5, 0, 0);
        checkOutput("mult_lat", 64'(lat), 64'd33);
        checkOutput("mult_hi", hi, 32'hFFFFFFFF);
        checkOutput("mult_lo", lo, 32'hFFFFFFF1);
        applyStimulus(2'b11, 32'hFFFFFFF9, 32'd2, 0, 0);
        checkOutput("div_lat", 64'(lat), 64'd33);
        checkOutput("div_lo", lo, 32'hFFFFFFFD);
        checkOutput("div_hi", hi, 32'hFFFFFFFF);
`else
        $display("[TB] op[0] treated as unsigned");
        applyStimulus(2'b01, 32'hFFFFFFFD, 32'd5, 0, 0);
        checkOutput("mult_lat", 64'(lat), 64'd33);
        checkOutput("mult_hi", hi, 32'h00000004);
        checkOutput("mult_lo", lo, 32'hFFFFFFF1);
        applyStimulus(2'b11, 32'hFFFFFFF9, 32'd2, 0, 0);
        checkOutput("div_lat", 64'(lat), 64'd33);
        checkOutput("div_lo", lo, 32'h7FFFFFFC);
        checkOutput("div_hi", hi, 32'h00000001);
`endif

        $display("[TB] divide by zero");
        writeHiLo(32'hA, 32'hB);
        applyStimulus(2'b10, 32'h12345678, 32'd0, 0, 0);
        checkOutput("dz_lat", 64'(lat), 64'd1);
        checkOutput("dz_flag", dz_seen, 1);
        checkOutput("dz_busy_cycles", 64'(busy_cnt), 64'd0);
        checkOutput("dz_done_pulses", 64'(done_cnt), 64'd1);
        checkOutput("dz_hi", hi, 32'hA);
        checkOutput("dz_lo", lo, 32'hB);
        applyStimulus(2'b11, 32'h5, 32'd0, 0, 0);
        checkOutput("dz_div_lat", 64'(lat), 64'd1);
        checkOutput("dz_div_flag", dz_seen, 1);

        $display("[TB] start and MTHI while busy");
        applyStimulus(2'b10, 32'd100, 32'd7, 1, 5);
        checkOutput("ign_lat", 64'(lat), 64'd33);
        checkOutput("ign_done_pulses", 64'(done_cnt), 64'd1);
        checkOutput("ign_lo", lo, 32'd14);
        checkOutput("ign_hi", hi, 32'd2);

        $display("[TB] cancel mid-run");
        writeHiLo(32'h1111, 32'h2222);
        applyStimulus(2'b00, 32'd3, 32'd4, 2, 10);
        checkOutput("cancel_done_pulses", 64'(done_cnt), 64'd0);
        checkOutput("cancel_busy_cycles", 64'(busy_cnt), 64'd10);
        checkOutput("cancel_hi", hi, 32'h1111);
        checkOutput("cancel_lo", lo, 32'h2222);
        applyStimulus(2'b00, 32'd3, 32'd4, 0, 0);
        checkOutput("after_cancel_lat", 64'(lat), 64'd33);
        checkOutput("after_cancel_hi", hi, 32'd0);
        checkOutput("after_cancel_lo", lo, 32'd12);

        $display("[TB] cancel suppresses start, MTHI in idle");
        start  = 1'b1;
        cancel = 1'b1;
        hi_we  = 1'b1;
        op     = 2'b00;
        a      = 32'd9;
        b      = 32'd9;
        wdata  = 32'h77;
        @(posedge clk); #1;
        start  = 1'b0;
        cancel = 1'b0;
        hi_we  = 1'b0;
        checkOutput("supp_busy", busy, 0);
        checkOutput("supp_hi", hi, 32'h77);
        @(posedge clk); #1;
        checkOutput("supp_done", done, 0);

        $display("[TB] reset mid-run");
        writeHiLo(32'h3333, 32'h4444);
        applyStimulus(2'b10, 32'hFFFFFFFF, 32'd3, 3, 20);
        checkOutput("rst_done_pulses", 64'(done_cnt), 64'd0);
        checkOutput("rst_busy_cycles", 64'(busy_cnt), 64'd20);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_hi", hi, 32'd0);
        checkOutput("rst_lo", lo, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
